// File: rtl/glitc_intercom_command_decoder.sv
// Intercom byte decoder: tracks link lock from legal/illegal byte runs, emits
// registered command pulses, manages the pong request handshake and error statistics.
module glitc_intercom_command_decoder #(
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_ERRORS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_dat_i,
    input  logic       rx_valid_i,
    input  logic       pong_ack_i,
    input  logic       err_clr_i,
    output logic       sync_o,
    output logic       ping_o,
    output logic       pong_o,
    output logic       train_o,
    output logic       err_o,
    output logic       locked_o,
    output logic       pong_req_o,
    output logic       ping_overrun_o,
    output logic [7:0] err_count_o,
    output logic [1:0] state_o
);

    localparam logic [7:0] CODE_SYNC  = 8'h27;
    localparam logic [7:0] CODE_PING  = 8'h07;
    localparam logic [7:0] CODE_PONG  = 8'h17;
    localparam logic [7:0] CODE_TRAIN = 8'hB7;
    localparam logic [7:0] CODE_IDLE  = 8'h9F;
    localparam logic [7:0] LOCK_TGT   = 8'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_ERRORS);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [7:0] run_cnt, run_cnt_next, run_inc;
    logic [3:0] bad_cnt, bad_cnt_next, bad_inc;
    logic       legal, bad, cmd_ok, ping_hit;

    always_comb begin
        legal = 1'b0;
        case (rx_dat_i)
            CODE_SYNC, CODE_PING, CODE_PONG, CODE_TRAIN, CODE_IDLE: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign bad      = rx_valid_i && !legal;
    assign cmd_ok   = rx_valid_i && legal && (state == LOCKED);
    assign ping_hit = cmd_ok && (rx_dat_i == CODE_PING);
    assign run_inc  = run_cnt + 8'd1;
    assign bad_inc  = bad_cnt + 4'd1;
    assign state_o  = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= HUNT;
            run_cnt <= '0;
            bad_cnt <= '0;
        end else begin
            state   <= state_next;
            run_cnt <= run_cnt_next;
            bad_cnt <= bad_cnt_next;
        end
    end

    // Only evaluated bytes move the lock machine; idle cycles hold everything.
    always_comb begin
        state_next   = state;
        run_cnt_next = run_cnt;
        bad_cnt_next = bad_cnt;
        if (rx_valid_i) begin
            case (state)
                HUNT: begin
                    if (legal) begin
                        state_next   = VERIFY;
                        run_cnt_next = 8'd1;
                    end
                end
                VERIFY: begin
                    if (legal) begin
                        run_cnt_next = run_inc;
                        if (run_inc == LOCK_TGT) state_next = LOCKED;
                    end else begin
                        state_next   = HUNT;
                        run_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    if (legal) begin
                        bad_cnt_next = '0;
                    end else if (bad_inc == UNLOCK_TGT) begin
                        state_next   = HUNT;
                        run_cnt_next = '0;
                        bad_cnt_next = '0;
                    end else begin
                        bad_cnt_next = bad_inc;
                    end
                end
                default: begin
                    state_next   = HUNT;
                    run_cnt_next = '0;
                    bad_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_o         <= 1'b0;
            ping_o         <= 1'b0;
            pong_o         <= 1'b0;
            train_o        <= 1'b0;
            err_o          <= 1'b0;
            locked_o       <= 1'b0;
            pong_req_o     <= 1'b0;
            ping_overrun_o <= 1'b0;
            err_count_o    <= '0;
        end else begin
            sync_o   <= cmd_ok && (rx_dat_i == CODE_SYNC);
            ping_o   <= ping_hit;
            pong_o   <= cmd_ok && (rx_dat_i == CODE_PONG);
            train_o  <= cmd_ok && (rx_dat_i == CODE_TRAIN);
            err_o    <= bad;
            locked_o <= (state_next == LOCKED);
            // A fresh ping wins over a coincident ack so the new request is not lost.
            if (ping_hit)        pong_req_o <= 1'b1;
            else if (pong_ack_i) pong_req_o <= 1'b0;
            if (ping_hit && pong_req_o && !pong_ack_i) ping_overrun_o <= 1'b1;
            if (err_clr_i)                        err_count_o <= {7'd0, bad};
            else if (bad && err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_glitc_intercom_command_decoder.sv
// Scoreboard bench for the intercom command decoder: directed scenarios plus
// randomized traffic, checked against a behavioural link model.
module tb_glitc_intercom_command_decoder;

    localparam int LOCK_COUNT    = 16;
    localparam int UNLOCK_ERRORS = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] rx_dat_i = '0;
    logic       rx_valid_i = 1'b0;
    logic       pong_ack_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic       sync_o, ping_o, pong_o, train_o, err_o, locked_o;
    logic       pong_req_o, ping_overrun_o;
    logic [7:0] err_count_o;
    logic [1:0] state_o;

    glitc_intercom_command_decoder #(
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_ERRORS(UNLOCK_ERRORS)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .rx_dat_i      (rx_dat_i),
        .rx_valid_i    (rx_valid_i),
        .pong_ack_i    (pong_ack_i),
        .err_clr_i     (err_clr_i),
        .sync_o        (sync_o),
        .ping_o        (ping_o),
        .pong_o        (pong_o),
        .train_o       (train_o),
        .err_o         (err_o),
        .locked_o      (locked_o),
        .pong_req_o    (pong_req_o),
        .ping_overrun_o(ping_overrun_o),
        .err_count_o   (err_count_o),
        .state_o       (state_o)
    );

    // clock
    always #5 clk = ~clk;

    // reference model state
    logic [15:0] exp_q[$];
    int  compared = 0;
    int  mismatched = 0;
    int  m_run = 0, m_bad = 0, m_cnt = 0;
    bit  m_locked = 0, m_req = 0, m_ovr = 0;
    logic [7:0] codes [5] = '{8'h27, 8'h07, 8'h17, 8'hB7, 8'h9F};

    function automatic bit is_legal(input logic [7:0] d);
        for (int i = 0; i < 5; i++) if (codes[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle of stimulus; the model predicts what the outputs show after the edge.
    task automatic step(input logic [7:0] d, input bit v, input bit ack, input bit clr, input bit rst);
        bit s, p, po, t, er, legal;
        @(negedge clk);
        rx_dat_i = d; rx_valid_i = v; pong_ack_i = ack; err_clr_i = clr; rst_i = rst;
        s = 0; p = 0; po = 0; t = 0; er = 0;
        if (rst) begin
            m_run = 0; m_bad = 0; m_cnt = 0; m_locked = 0; m_req = 0; m_ovr = 0;
        end else begin
            legal = is_legal(d);
            er = v && !legal;
            if (v && legal && m_locked) begin
                s = (d == 8'h27); p = (d == 8'h07); po = (d == 8'h17); t = (d == 8'hB7);
            end
            if (p) begin
                if (m_req && !ack) m_ovr = 1;
                m_req = 1;
            end else if (ack) begin
                m_req = 0;
            end
            if (clr) m_cnt = er ? 1 : 0;
            else if (er && m_cnt < 255) m_cnt++;
            if (v) begin
                if (m_locked) begin
                    if (legal) m_bad = 0;
                    else begin
                        m_bad++;
                        if (m_bad == UNLOCK_ERRORS) begin m_locked = 0; m_run = 0; m_bad = 0; end
                    end
                end else if (legal) begin
                    m_run++;
                    if (m_run == LOCK_COUNT) begin m_locked = 1; m_bad = 0; end
                end else begin
                    m_run = 0;
                end
            end
        end
        exp_q.push_back({s, p, po, t, er, m_locked, m_req, m_ovr, m_cnt[7:0]});
    endtask

    task automatic send(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) step(d, 1, 0, 0, 0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(8'($urandom), 0, 0, 0, 0);
    endtask

    // monitor: compare every cycle that has a pending expectation
    always @(posedge clk) begin
        logic [15:0] got, exp;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {sync_o, ping_o, pong_o, train_o, err_o, locked_o,
                   pong_req_o, ping_overrun_o, err_count_o};
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL outputs t=%0t got {s,p,po,t,e,lk,rq,ov,cnt}=%b_%h required %b_%h",
                         $time, got[15:8], got[7:0], exp[15:8], exp[7:0]);
            end
        end
    end

    initial begin
        int pl;
        // reset and lock acquisition
        step(8'h00, 0, 0, 0, 1);
        send(8'h9F, 16);
        gap(2);
        step(8'h00, 0, 0, 0, 1);
        send(8'h9F, 15);
        send(8'h55, 1);
        gap(2);
        // decode while locked
        send(8'h9F, 16);
        send(8'h27, 1); gap(2);
        send(8'h17, 1); gap(1);
        send(8'hB7, 1); gap(3);
        send(8'h9F, 1); gap(1);
        send(8'h0F, 1); gap(1);
        // unlock
        send(8'h00, 3); send(8'h9F, 1); send(8'h00, 4);
        gap(2);
        // pong handshake
        send(8'h9F, 16);
        send(8'h07, 1); gap(1);
        send(8'h07, 1); gap(1);
        step(8'h00, 0, 1, 0, 0); gap(1);
        send(8'h07, 1);
        step(8'h07, 1, 1, 0, 0);
        step(8'h00, 0, 1, 0, 0);
        step(8'h00, 0, 1, 0, 0);
        // error counter saturation and clear
        send(8'h00, 300);
        step(8'hAA, 1, 0, 1, 0);
        step(8'h00, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(8'($urandom), 0, 0, 0, 0);
        // reset mid-lock with a pending pong
        send(8'h9F, 16);
        send(8'h07, 1);
        step(8'h07, 1, 0, 0, 1);
        send(8'h9F, 15);
        gap(2);
        // randomized traffic in segments of varying legality bias
        for (int seg = 0; seg < 60; seg++) begin
            pl = (seg % 3 == 0) ? 60 : 97;
            for (int i = 0; i < 50; i++) begin
                logic [7:0] d;
                d = ($urandom_range(99) < pl) ? codes[$urandom_range(4)] : 8'($urandom);
                step(d, $urandom_range(99) < 85, $urandom_range(99) < 15,
                     $urandom_range(99) < 3, $urandom_range(999) < 4);
            end
        end
        @(negedge clk);
        rx_valid_i = 0; pong_ack_i = 0; err_clr_i = 0; rst_i = 0;
        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/glitc_intercom_command_decoder.md
GLITC_INTERCOM_COMMAND_DECODER -- requirements
Module: glitc_intercom_command_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 16: number of consecutive legal bytes needed to declare lock; legal range 2..255.
REQ-002 Parameter UNLOCK_ERRORS, default 4: number of consecutive illegal bytes that drops lock; legal range 1..15.
REQ-003 clk_i  input  1  single clock; all logic is synchronous to its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 rx_dat_i  input  8  received intercom byte.
REQ-006 rx_valid_i  input  1  rx_dat_i is valid this cycle.
REQ-007 pong_ack_i  input  1  transmit side has accepted the pending pong request.
REQ-008 err_clr_i  input  1  clears err_count_o.
REQ-009 sync_o, ping_o, pong_o, train_o  output  1 each  single-cycle decoded-command pulses.
REQ-010 err_o  output  1  single-cycle pulse marking an illegal byte.
REQ-011 locked_o  output  1  link lock status.
REQ-012 pong_req_o  output  1  request to send a pong, held until acknowledged.
REQ-013 ping_overrun_o  output  1  sticky flag: a ping arrived while a pong request was still pending.
REQ-014 err_count_o  output  8  saturating count of illegal bytes.

Function
REQ-015 Legal bytes are exactly 0x27 (SYNC), 0x07 (PING), 0x17 (PONG), 0xB7 (TRAIN) and 0x9F (IDLE); every other value is illegal, including bytes with bits[2:0]=3'b111 and an unlisted bits[7:3].
REQ-016 Only cycles with rx_valid_i=1 are evaluated; cycles with rx_valid_i=0 change no state and produce no pulses.
REQ-017 All outputs are registered; pulses appear exactly 1 cycle after the evaluated byte.
REQ-018 Lock FSM states and transitions:
- HUNT: legal byte -> VERIFY with run counter=1.
- VERIFY: legal byte -> run counter +1; when the counter reaches LOCK_COUNT -> LOCKED. Illegal byte -> HUNT with counter=0.
- LOCKED: illegal byte -> consecutive-error counter +1; when it reaches UNLOCK_ERRORS -> HUNT with both counters=0. Legal byte -> consecutive-error counter=0.
REQ-019 locked_o=1 exactly while the state is LOCKED; it is asserted in the cycle after the LOCK_COUNT-th legal byte.
REQ-020 sync_o, ping_o, pong_o and train_o pulse only when the FSM was LOCKED at evaluation time; IDLE produces no pulse.
REQ-021 err_o pulses for every illegal byte, in any state.
REQ-022 err_count_o: +1 per illegal byte, saturating at 255.
- err_clr_i alone -> 0.
- err_clr_i together with an illegal byte -> 1.
REQ-023 A PING decoded while locked sets pong_req_o=1. pong_req_o is cleared in the cycle after pong_ack_i=1.
- Ack and a new PING in the same cycle -> pong_req_o stays 1.
- Ack while pong_req_o=0 is ignored.
REQ-024 A PING decoded while pong_req_o=1 and no ack is present sets ping_overrun_o=1; it is cleared only by rst_i.
REQ-025 Loss of lock does not clear pong_req_o.
REQ-026 The IDLE code counts as a legal byte for lock acquisition.

Reset
REQ-027 With rst_i=1 at a clock edge, the next cycle shows:
- state HUNT, both counters 0;
- locked_o, pong_req_o, ping_overrun_o and all pulses 0;
- err_count_o 0.
REQ-028 Reset asserted mid-operation (in VERIFY, in LOCKED, or with a pending pong) takes priority over all inputs in that cycle.

Verification
REQ-029 Lock: 16 x 0x9F -> locked_o=1 one cycle after the 16th byte; 15 x 0x9F then 0x55 -> locked_o stays 0, err_o pulses once, err_count_o=1.
REQ-030 Decode: when locked, send 0x27, 0x17, 0xB7, 0x9F with gaps -> exactly one pulse each of sync_o, pong_o, train_o, one cycle after the byte, and no pulse for 0x9F; send 0x0F -> err_o only.
REQ-031 Unlock: when locked, 3 x 0x00 then 0x9F, then 4 x 0x00 -> locked_o stays 1 after the first burst and drops one cycle after the 4th byte of the second burst.
REQ-032 Pong handshake: when locked, 0x07 -> pong_req_o=1; 0x07 again with no ack -> ping_overrun_o=1; pong_ack_i -> pong_req_o=0 next cycle; ack coincident with a new 0x07 -> pong_req_o remains 1.
REQ-033 Error counter: 300 illegal bytes -> err_count_o=255; err_clr_i with an illegal byte -> 1; rx_valid_i=0 with arbitrary data -> no change.
REQ-034 Reset mid-lock: when locked with pong_req_o=1, assert rst_i for 1 cycle -> all outputs 0; 15 x 0x9F afterwards -> locked_o still 0.
